int_timer: RTL

INT_TIMER -- requirements
Module: int_timer

---
 rtl/int_ctrl_pkg.sv | 27 ++
 rtl/int_tick_gen.sv | 34 +++
 rtl/int_timer.sv | 109 ++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared timer/interrupt-controller definitions: state encoding, defaults, sel clamp.
package int_ctrl_pkg;

  localparam int unsigned TICK_CYC_DEF = 6554;
  localparam int unsigned SEL_MAX_DEF  = 300;
  localparam int unsigned SEL_W        = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Force a requested period into [1;sel_max].
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel,
                                                  input logic [SEL_W-1:0] sel_max);
    logic [SEL_W-1:0] res;
    res = sel;
    if (sel == '0) begin
      res = SEL_W'(1);
    end else if (sel > sel_max) begin
      res = sel_max;
    end
    return res;
  endfunction

endpackage

// File: rtl/int_tick_gen.sv
// Prescaler: counts clk_32k cycles while run is high and flags the wrap cycle.
module int_tick_gen
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYC = TICK_CYC_DEF
) (
  input  logic clk_32k,
  input  logic rst,
  input  logic run,
  output logic tick_c
);

  localparam int unsigned     CNT_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_CYC-1 while running; held at zero otherwise.
  always_ff @(posedge clk_32k or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick is the edge on which the counter wraps.
  assign tick_c = run && (cnt == CNT_LAST);

endmodule

// File: rtl/int_timer.sv
// Periodic / single-shot interrupt timer counting 0.2 s ticks of a 32 kHz clock.
module int_timer
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYC = TICK_CYC_DEF,
  parameter int unsigned SEL_MAX  = SEL_MAX_DEF
) (
  input  logic             clk_32k,
  input  logic             rst,
  input  logic             rg_timer_on,
  input  logic             rg_timer_mode,
  input  logic [SEL_W-1:0] rg_timer_sel,
  output logic             timer_int_flag,
  output logic             timer_busy,
  output logic [SEL_W-1:0] timer_remain
);

  localparam logic [SEL_W-1:0] SEL_MAX_V = SEL_W'(SEL_MAX);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [SEL_W-1:0] tick_cnt, tick_nxt;
  logic [SEL_W-1:0] tick_inc;
  logic [SEL_W-1:0] remain_nxt;
  logic             flag_nxt;
  logic             busy_nxt;
  logic             run_c;
  logic             tick_c;

  // Prescaler stops the same edge that on drops, so counters clear together.
  assign run_c = (state == ST_RUN) && rg_timer_on;

  int_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_gen (
    .clk_32k (clk_32k),
    .rst     (rst),
    .run     (run_c),
    .tick_c  (tick_c)
  );

  assign tick_inc = tick_cnt + SEL_W'(1);

  // Next-state, period bookkeeping and next output values.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    tick_nxt  = tick_cnt;
    flag_nxt  = 1'b0;

    if (!rg_timer_on) begin
      state_nxt = ST_IDLE;
      tick_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RUN;
          sel_nxt   = clamp_sel(rg_timer_sel, SEL_MAX_V);
          tick_nxt  = '0;
        end
        ST_RUN: begin
          if (tick_c) begin
            if (tick_inc == sel_q) begin
              flag_nxt = 1'b1;
              tick_nxt = '0;
              if (rg_timer_mode) begin
                sel_nxt = clamp_sel(rg_timer_sel, SEL_MAX_V);
              end else begin
                state_nxt = ST_DONE;
              end
            end else begin
              tick_nxt = tick_inc;
            end
          end
        end
        ST_DONE: begin
          tick_nxt = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
        end
      endcase
    end

    busy_nxt   = (state_nxt == ST_RUN);
    remain_nxt = busy_nxt ? (sel_nxt - tick_nxt) : '0;
  end

  // State, latched period and registered outputs.
  always_ff @(posedge clk_32k or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      sel_q          <= SEL_W'(1);
      tick_cnt       <= '0;
      timer_int_flag <= 1'b0;
      timer_busy     <= 1'b0;
      timer_remain   <= '0;
    end else begin
      state          <= state_nxt;
      sel_q          <= sel_nxt;
      tick_cnt       <= tick_nxt;
      timer_int_flag <= flag_nxt;
      timer_busy     <= busy_nxt;
      timer_remain   <= remain_nxt;
    end
  end

endmodule
